// File: rtl/debug_tx_sequencer.sv
// Serializes a 32-bit debug word into bytes for a UART transmitter using a tx_start/tx_done handshake.
// Optional feature macro DEBUG_TX_CHECKSUM_EN appends an XOR checksum byte after each word.
module debug_tx_sequencer #(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data,
   input  logic        data_start,
   input  logic        tx_done,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic        data_ready,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
`ifdef DEBUG_TX_CHECKSUM_EN
      , CSUM = 2'd3
`endif
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic        data_ready_q, data_ready_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
`ifdef DEBUG_TX_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   // The byte on the wire is always at the head of the shift register.
   function automatic logic [7:0] head_byte(input logic [31:0] w);
      return LSB_FIRST ? w[7:0] : w[31:24];
   endfunction

   function automatic logic [31:0] advance(input logic [31:0] w);
      return LSB_FIRST ? {8'h00, w[31:8]} : {w[23:0], 8'h00};
   endfunction

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      data_ready_d = 1'b0;
      overrun_d    = overrun_q | (data_start & busy_q);
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_d       = csum_q;
`endif

      case (state_q)
         IDLE: begin
            if (data_start) begin
               state_d    = LOAD;
               shift_d    = data;
               cnt_d      = 2'd0;
               tx_data_d  = head_byte(data);
               tx_start_d = 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
               csum_d     = data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
`endif
            end
         end
         LOAD: state_d = WAIT;
         WAIT: begin
            if (tx_done) begin
               if (cnt_q != 2'd3) begin
                  state_d    = LOAD;
                  cnt_d      = cnt_q + 2'd1;
                  shift_d    = advance(shift_q);
                  tx_data_d  = head_byte(advance(shift_q));
                  tx_start_d = 1'b1;
               end else begin
`ifdef DEBUG_TX_CHECKSUM_EN
                  state_d    = CSUM;
                  tx_data_d  = csum_q;
                  tx_start_d = 1'b1;
`else
                  state_d      = IDLE;
                  data_ready_d = 1'b1;
`endif
               end
            end
         end
`ifdef DEBUG_TX_CHECKSUM_EN
         // The first CSUM cycle carries tx_start; its tx_done only counts afterwards.
         CSUM: begin
            if (tx_done && !tx_start_q) begin
               state_d      = IDLE;
               data_ready_d = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shift_q      <= 32'h0;
         cnt_q        <= 2'd0;
         tx_data_q    <= 8'h00;
         tx_start_q   <= 1'b0;
         data_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
         csum_q       <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         data_ready_q <= data_ready_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
`ifdef DEBUG_TX_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign data_ready = data_ready_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;

endmodule

// File: doc/debug_tx_sequencer.md
DEBUG_TX_SEQUENCER -- requirements
Module: debug_tx_sequencer

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 0, which selects byte order: 0 sends data[31:24] first; 1 sends data[7:0] first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port data, input, 32 bits: the word to transmit, sampled only when data_start is accepted.
REQ-005 The block SHALL have port data_start, input, 1 bit: a one-cycle request to send data.
REQ-006 The block SHALL have port tx_done, input, 1 bit: a one-cycle pulse from the UART transmitter when a byte has finished.
REQ-007 The block SHALL have port tx_data, output, 8 bits: the byte presented to the UART transmitter.
REQ-008 The block SHALL have port tx_start, output, 1 bit: a one-cycle pulse that launches transmission of tx_data.
REQ-009 The block SHALL have port data_ready, output, 1 bit: a one-cycle pulse meaning the word is fully sent and the block can accept the next one.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port overrun, output, 1 bit: a sticky flag set when a request is dropped.

Function
REQ-012 The state machine SHALL have states IDLE, LOAD, WAIT and, with the option in REQ-027, CSUM; all outputs SHALL be registered.
REQ-013 In IDLE, data_start=1 SHALL latch data into a 32-bit shift register, clear the byte counter and move to LOAD.
REQ-014 In LOAD, the block SHALL drive tx_start=1 for exactly one cycle, put the current byte on tx_data, then move to WAIT.
- First tx_start is the cycle after data_start is accepted (latency 1).
REQ-015 tx_data SHALL hold steady from the tx_start cycle until the matching tx_done.
REQ-016 In WAIT, tx_done=1 with byte counter <3 SHALL increment the counter, shift to the next byte and return to LOAD; next tx_start comes 1 cycle after tx_done.
REQ-017 In WAIT, tx_done=1 with byte counter =3 SHALL move to IDLE (or CSUM, REQ-027) and pulse data_ready=1 in the first IDLE cycle.
REQ-018 A data_start in the same cycle as data_ready SHALL be accepted as a new request; back-to-back words therefore have no dead cycle.
REQ-019 tx_done SHALL be ignored in IDLE and LOAD.
REQ-020 A data_start while busy=1 SHALL be dropped, leave the word in progress unchanged, and set overrun=1; overrun clears only on reset.
REQ-021 Simultaneous tx_done and data_start in WAIT: tx_done SHALL be processed and data_start handled per REQ-020.
REQ-022 The byte counter SHALL be 2 bits and count 0..3; it SHALL never wrap while busy.

Reset
REQ-023 With rst_n=0 the block SHALL immediately, independent of clk, enter IDLE.
REQ-024 Reset values SHALL be: tx_data=8'h00, tx_start=0, data_ready=0, busy=0, overrun=0; shift register, counter and checksum = 0.
REQ-025 Reset in the middle of a word SHALL abandon it with no data_ready; a tx_done after reset SHALL be ignored.
REQ-026 Deassertion of rst_n SHALL take effect on the next clk rising edge; the first data_start can be accepted on that edge.

Configuration
REQ-027 Macro DEBUG_TX_CHECKSUM_EN, when defined:
- An 8-bit XOR of the four bytes is kept.
- After the 4th tx_done the block goes to CSUM, which pulses tx_start with tx_data=checksum, waits for tx_done, then returns to IDLE.
- data_ready follows the 5th byte, and busy stays high through CSUM.
REQ-028 Without DEBUG_TX_CHECKSUM_EN, the CSUM state and checksum register SHALL not exist and exactly 4 bytes are sent per word.

Verification
REQ-029 LSB_FIRST=0, data=32'hDEADBEEF, tx_done 10 cycles after each tx_start -> tx_data DE,AD,BE,EF with one tx_start each, then one data_ready pulse.
REQ-030 LSB_FIRST=1, data=32'h12345678 -> bytes 78,56,34,12.
REQ-031 data_start with 32'h00000001 in the data_ready cycle of the previous word -> tx_start the next cycle with 00, overrun stays 0.
REQ-032 data_start with 32'hFFFFFFFF while sending 32'hA5A5A5A5 -> bytes stay A5 x4, overrun=1 until reset.
REQ-033 rst_n=0 after the 2nd byte -> outputs at reset values immediately, no data_ready; a stray tx_done is ignored.
REQ-034 DEBUG_TX_CHECKSUM_EN defined, data=32'h01020304 -> bytes 01,02,03,04,04 (XOR), data_ready after the 5th tx_done.
